// File: rtl/snn_result_collector.sv
// snn_result_collector: reduces each SNN_Core tile to max, argmax, sum
// and tile number, then offers the summary downstream over valid/ready.
module snn_result_collector #(
    parameter int DATA_W       = 8,
    parameter int RESULT_COUNT = 16,
    parameter int IDX_W        = 4,
    parameter int TILE_W       = 16
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iStart,
    input  logic [DATA_W-1:0]       iResult,
    input  logic                    iValid,
    input  logic                    iReady,
    output logic                    oValid,
    output logic [DATA_W-1:0]       oMaxVal,
    output logic [IDX_W-1:0]        oMaxIdx,
    output logic [DATA_W+IDX_W-1:0] oSum,
    output logic [TILE_W-1:0]       oTileIdx,
    output logic                    oBusy,
    output logic                    oErr
);

    localparam int SUM_W = DATA_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RESULT_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]  r_cnt;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              r_pend;
    logic [TILE_W-1:0] r_tile;
    logic              r_err;
    logic              r_valid;
    logic [DATA_W-1:0] r_o_max;
    logic [IDX_W-1:0]  r_o_idx;
    logic [SUM_W-1:0]  r_o_sum;
    logic [TILE_W-1:0] r_o_tile;

    logic              w_take;
    logic              w_last;
    logic              w_new_max;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [DATA_W-1:0] w_max_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_hold_exit;
    logic              w_restart;
    logic              w_clear;
    logic              w_err_set;

    // A start in ACCUM wins over a word arriving in the same cycle.
    assign w_take      = (r_state == S_ACCUM) && iValid && !iStart;
    assign w_last      = w_take && (r_cnt == LAST);
    assign w_new_max   = (r_cnt == '0) || (iResult > r_max);
    assign w_sum_nxt   = r_sum + SUM_W'(iResult);
    assign w_max_nxt   = w_new_max ? iResult : r_max;
    assign w_idx_nxt   = w_new_max ? r_cnt : r_idx;
    assign w_hold_exit = (r_state == S_HOLD) && r_valid && iReady && !iValid;
    assign w_restart   = w_hold_exit && (r_pend || iStart);

    assign w_clear = ((r_state == S_IDLE) && iStart)
                   || ((r_state == S_ACCUM) && iStart)
                   || w_restart;

    assign w_err_set = ((r_state == S_IDLE) && iValid)
                     || ((r_state == S_ACCUM) && iStart)
                     || ((r_state == S_HOLD) && iValid);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (iStart) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_last) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_hold_exit) w_state_nxt = w_restart ? S_ACCUM : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_max <= '0;
            r_idx <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_max <= '0;
            r_idx <= '0;
        end else if (w_take) begin
            r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
            r_sum <= w_sum_nxt;
            r_max <= w_max_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // Summary is loaded from the next-values so oValid lags the last word by one cycle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_valid  <= 1'b0;
            r_o_max  <= '0;
            r_o_idx  <= '0;
            r_o_sum  <= '0;
            r_o_tile <= '0;
            r_tile   <= '0;
        end else if (w_last) begin
            r_valid  <= 1'b1;
            r_o_max  <= w_max_nxt;
            r_o_idx  <= w_idx_nxt;
            r_o_sum  <= w_sum_nxt;
            r_o_tile <= r_tile;
        end else if (w_hold_exit) begin
            r_valid <= 1'b0;
            r_tile  <= r_tile + TILE_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_pend <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_hold_exit) begin
                r_pend <= 1'b0;
            end else if ((r_state == S_HOLD) && iStart) begin
                r_pend <= 1'b1;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign oValid   = r_valid;
    assign oMaxVal  = r_o_max;
    assign oMaxIdx  = r_o_idx;
    assign oSum     = r_o_sum;
    assign oTileIdx = r_o_tile;
    assign oBusy    = (r_state == S_ACCUM);
    assign oErr     = r_err;

endmodule

// File: doc/snn_result_collector.md
Name: snn_result_collector

Overview:
Downstream stage of SNN_Core. Consumes the per-tile oResult/oValid stream that SNN_Core produces for each 16x16 tile. Reduces each tile's RESULT_COUNT results to a summary: max value, index of max, sum, and tile number. Presents the summary to the next stage (classifier / host readout) over a valid/ready handshake.

Parameters:
DATA_W, 8, width of one SNN_Core result
RESULT_COUNT, 16, number of results that make up one tile
IDX_W, 4, width of the result index; 2**IDX_W >= RESULT_COUNT required
TILE_W, 16, width of the tile counter

Ports:
iClk  in  1  system clock, rising edge
iRst  in  1  asynchronous, active-high reset
iStart  in  1  one-cycle pulse: a new tile begins; same pulse that is sent to SNN_Core
iResult  in  DATA_W  result word from SNN_Core oResult
iValid  in  1  iResult valid; from SNN_Core oValid; no backpressure upstream
iReady  in  1  downstream accepts the summary
oValid  out  1  summary valid; held until accepted
oMaxVal  out  DATA_W  largest result in the tile
oMaxIdx  out  IDX_W  arrival index (0-based) of oMaxVal
oSum  out  DATA_W+IDX_W  unsigned sum of the tile's results
oTileIdx  out  TILE_W  number of the tile being summarised, starts at 0
oBusy  out  1  high in ACCUM
oErr  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, clocked release): state IDLE; all outputs 0; counters, accumulators and pending-start flag cleared.
- Clock and reset: one clock iClk; reset iRst is asynchronous and active-high.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - iStart -> ACCUM. Clears cnt, sum and max; max index = 0.
  - iValid in IDLE, including the same cycle as iStart: word dropped, oErr <= 1.
- ACCUM, on each iValid:
  - sum += iResult, computed at full width DATA_W+IDX_W with no overflow.
  - If cnt==0 or iResult > max (strict compare), then max <= iResult and idx <= cnt. Ties keep the lowest index.
  - cnt++.
- ACCUM, completion:
  - The iValid at cnt==RESULT_COUNT-1 updates the accumulators. Next cycle: summary registers loaded, oValid=1, state HOLD.
  - Latency is 1 cycle from the last accepted result to oValid.
- ACCUM, restart: iStart during ACCUM (any cnt) discards the partial tile, clears the accumulators and sets oErr. State stays ACCUM. oTileIdx is not advanced. Any iValid in that same cycle is dropped.
- HOLD:
  - oValid, oMaxVal, oMaxIdx, oSum and oTileIdx are stable until iReady.
  - iValid in HOLD: word dropped, oErr <= 1.
  - iStart in HOLD sets the pending flag.
- HOLD exit: on iValid-free cycle with oValid&iReady:
  - oValid <= 0 and tile counter +1 (wraps at 2**TILE_W).
  - If pending or iStart is set this cycle: go to ACCUM with cleared accumulators, pending <= 0. Otherwise go to IDLE.
- oTileIdx shows the counter value captured at summary load.
- oErr is cleared only by reset.
- oBusy = (state==ACCUM).

Test Plan:
- Reset, iStart, then 16 results 0x00..0x0F on consecutive cycles, iReady=1 -> one cycle after the last result: oValid=1, oMaxVal=0x0F, oMaxIdx=15, oSum=0x078, oTileIdx=0, oErr=0.
- 16 results all 0x42 -> oMaxVal=0x42, oMaxIdx=0, oSum=0x420. Next tile with 0xFF at index 5 and 0xFF at index 9 (all else 0x00) -> oMaxIdx=5, oSum=0x1FE, oTileIdx=1.
- iReady=0 for 8 cycles after oValid, with 2 stray iValid words -> summary unchanged and oValid held throughout; oErr=1. Raise iReady -> oValid drops the next cycle, state IDLE.
- iStart, 7 results of 0xFF, iStart again, then 16 results 0x01 -> single summary with oMaxVal=0x01, oSum=0x010, oTileIdx=0, oErr=1.
- iStart pulsed while in HOLD, then iReady -> goes straight to ACCUM (oBusy=1). The following 16 results produce a summary with oTileIdx incremented by 1.
- Assert iRst after 10 results in ACCUM -> all outputs 0 immediately, state IDLE. A fresh full tile after release summarises correctly with oTileIdx=0.
